// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// Status/Cause bit positions and MTC0 write masks.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_EBASE    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;
  localparam int CA_BD     = 31;
  localparam int CA_TI     = 30;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_HW_LO  = 10;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;

  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  function automatic logic [31:0] wmerge(
    input logic [31:0] cur,
    input logic [31:0] wd,
    input logic [31:0] mask
  );
    return (cur & ~mask) | (wd & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and sticky
// timer-interrupt flag.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2,
  parameter int TIMER_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  if (TIMER_EN != 0) begin : g_tmr
    logic [4:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        ti_q, ti_d;
    logic        wrap;

    // Prescaler/count update; a load beats the tick,
    // a Compare write clears TI even if a match lands.
    always_comb begin
      wrap    = (presc_q == 5'(COUNT_DIV - 1));
      presc_d = wrap ? 5'd0 : presc_q + 5'd1;
      count_d = wrap ? count_q + 32'd1 : count_q;
      cmp_d   = cmp_q;
      ti_d    = ti_q;
      if (count_we_i) begin
        count_d = wdata_i;
        presc_d = 5'd0;
      end
      if ((wrap || count_we_i) && count_d == cmp_q)
        ti_d = 1'b1;
      if (compare_we_i) begin
        cmp_d = wdata_i;
        ti_d  = 1'b0;
      end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        presc_q <= 5'd0;
        count_q <= 32'd0;
        cmp_q   <= 32'd0;
        ti_q    <= 1'b0;
      end else begin
        presc_q <= presc_d;
        count_q <= count_d;
        cmp_q   <= cmp_d;
        ti_q    <= ti_d;
      end
    end

    assign count_o   = count_q;
    assign compare_o = cmp_q;
    assign ti_o      = ti_q;
  end else begin : g_none
    logic unused_tmr;
    assign unused_tmr = ^{clk, rst, count_we_i,
                          compare_we_i, wdata_i};
    assign count_o   = 32'd0;
    assign compare_o = 32'd0;
    assign ti_o      = 1'b0;
  end

endmodule

// File: rtl/cp0_unit.sv
// CP0 system-control block: Status/Cause/EPC/BadVAddr/EBase,
// exception/ERET commit, interrupt request, timer.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          HW_INT_W  = 6,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] EBASE_RST = 32'h8000_0000,
  parameter int          TIMER_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          raddr_i,
  input  logic [HW_INT_W-1:0] int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic                eret_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                in_delay_slot_i,
  input  logic [31:0]         badvaddr_i,
  output logic [31:0]         rdata_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         ebase_o,
  output logic [31:0]         badvaddr_o,
  output logic                int_req_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;
  logic [31:0] ebase_q, ebase_d;
  logic        int_req_q, int_req_d;
  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  ip_hw;
  logic [31:0] cause_view;
  logic [31:0] rd_cur, rd_mask;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV),
    .TIMER_EN  (TIMER_EN)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && waddr_i == REG_COUNT),
    .compare_we_i (we_i && waddr_i == REG_COMPARE),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Live Cause view: hardware IP lines and TI merged in.
  always_comb begin
    ip_hw = 6'd0;
    ip_hw[HW_INT_W-1:0] = int_i;
    ip_hw[5] = ip_hw[5] | ti;
    cause_view = cause_q;
    cause_view[CA_TI] = ti;
    cause_view[CA_IP_HI:CA_HW_LO] = ip_hw;
  end

  // Next state: MTC0 first, then exception/ERET override.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    bva_d    = bva_q;
    ebase_d  = ebase_q;
    if (we_i && waddr_i == REG_STATUS)
      status_d = wmerge(status_q, wdata_i, STATUS_WMASK);
    if (we_i && waddr_i == REG_CAUSE)
      cause_d = wmerge(cause_q, wdata_i, CAUSE_WMASK);
    if (we_i && waddr_i == REG_EPC)
      epc_d = wdata_i;
    if (we_i && waddr_i == REG_EBASE)
      ebase_d = wmerge(ebase_q, wdata_i, EBASE_WMASK);
    if (exc_valid_i) begin
      status_d[ST_EXL] = 1'b1;
      cause_d[CA_EXC_HI:CA_EXC_LO] = exc_code_i;
      if (!status_q[ST_EXL]) begin
        epc_d = in_delay_slot_i ? exc_pc_i - 32'd4
                                : exc_pc_i;
        cause_d[CA_BD] = in_delay_slot_i;
      end
      if (exc_code_i == EXC_ADEL ||
          exc_code_i == EXC_ADES)
        bva_d = badvaddr_i;
    end else if (eret_i) begin
      status_d[ST_EXL] = 1'b0;
    end
    int_req_d = status_q[ST_IE] & ~status_q[ST_EXL] &
                (|(cause_view[CA_IP_HI:CA_IP_LO] &
                   status_q[ST_IM_HI:ST_IM_LO]));
  end

  // Architectural register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= STATUS_RST;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      bva_q     <= 32'd0;
      ebase_q   <= EBASE_RST;
      int_req_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      bva_q     <= bva_d;
      ebase_q   <= ebase_d;
      int_req_q <= int_req_d;
    end
  end

  // MFC0 read with same-cycle MTC0 bypass.
  always_comb begin
    rd_cur  = 32'd0;
    rd_mask = 32'd0;
    unique case (raddr_i)
      REG_BADVADDR: rd_cur = bva_q;
      REG_COUNT: begin
        rd_cur  = count;
        rd_mask = (TIMER_EN != 0) ? FULL_WMASK : 32'd0;
      end
      REG_COMPARE: begin
        rd_cur  = compare;
        rd_mask = (TIMER_EN != 0) ? FULL_WMASK : 32'd0;
      end
      REG_STATUS: begin
        rd_cur  = status_q;
        rd_mask = STATUS_WMASK;
      end
      REG_CAUSE: begin
        rd_cur  = cause_view;
        rd_mask = CAUSE_WMASK;
      end
      REG_EPC: begin
        rd_cur  = epc_q;
        rd_mask = FULL_WMASK;
      end
      REG_EBASE: begin
        rd_cur  = ebase_q;
        rd_mask = EBASE_WMASK;
      end
      default: begin
        rd_cur  = 32'd0;
        rd_mask = 32'd0;
      end
    endcase
    rdata_o = (we_i && waddr_i == raddr_i)
            ? wmerge(rd_cur, wdata_i, rd_mask)
            : rd_cur;
  end

  assign status_o   = status_q;
  assign cause_o    = cause_view;
  assign epc_o      = epc_q;
  assign ebase_o    = ebase_q;
  assign badvaddr_o = bva_q;
  assign int_req_o  = int_req_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: expected values queued at
// stimulus time, popped and asserted when outputs are sampled.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [5:0]  int_l;
  logic        exc_valid, eret, ds;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, badv;

  logic [31:0] rdata, status, cause, epc, ebase, bva;
  logic        int_req;

  logic [31:0] u1_rdata;
  logic [31:0] u1_unused_st, u1_unused_ca, u1_unused_epc;
  logic [31:0] u1_unused_eb, u1_unused_bv;
  logic        u1_unused_irq;
  logic [31:0] u2_rdata;
  logic [31:0] u2_unused_st, u2_unused_ca, u2_unused_epc;
  logic [31:0] u2_unused_eb, u2_unused_bv;
  logic        u2_unused_irq;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .int_i(int_l),
    .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .eret_i(eret), .exc_pc_i(exc_pc),
    .in_delay_slot_i(ds), .badvaddr_i(badv),
    .rdata_o(rdata), .status_o(status), .cause_o(cause),
    .epc_o(epc), .ebase_o(ebase), .badvaddr_o(bva),
    .int_req_o(int_req)
  );

  cp0_unit #(.COUNT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .int_i(int_l),
    .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .eret_i(eret), .exc_pc_i(exc_pc),
    .in_delay_slot_i(ds), .badvaddr_i(badv),
    .rdata_o(u1_rdata), .status_o(u1_unused_st),
    .cause_o(u1_unused_ca), .epc_o(u1_unused_epc),
    .ebase_o(u1_unused_eb), .badvaddr_o(u1_unused_bv),
    .int_req_o(u1_unused_irq)
  );

  cp0_unit #(.TIMER_EN(0)) dut2 (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_i(raddr), .int_i(int_l),
    .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .eret_i(eret), .exc_pc_i(exc_pc),
    .in_delay_slot_i(ds), .badvaddr_i(badv),
    .rdata_o(u2_rdata), .status_o(u2_unused_st),
    .cause_o(u2_unused_ca), .epc_o(u2_unused_epc),
    .ebase_o(u2_unused_eb), .badvaddr_o(u2_unused_bv),
    .int_req_o(u2_unused_irq)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sbq.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic mtc0(input logic [4:0] a,
                      input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr = '0; int_l = '0; exc_valid = 1'b0;
    exc_code = '0; eret = 1'b0; exc_pc = '0;
    ds = 1'b0; badv = '0;
    cyc(); cyc();
    rst = 1'b0;

    // reset state
    raddr = 5'd9;
    push("rst_status", 32'h1000_0000);
    push("rst_cause", 32'h0);
    push("rst_epc", 32'h0);
    push("rst_ebase", 32'h8000_0000);
    push("rst_bva", 32'h0);
    push("rst_intreq", 32'h0);
    push("rst_count", 32'h0);
    #1;
    chk(status); chk(cause); chk(epc);
    chk(ebase); chk(bva); chk({31'd0, int_req});
    chk(rdata);

    // timer: Compare=5, Count=0, DIV=2
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    push("ti_before", 32'h0);
    repeat (9) cyc();
    chk({31'd0, cause[30]});
    push("ti_set", 32'h1);
    push("count_at_ti", 32'd5);
    cyc();
    chk({31'd0, cause[30]});
    chk(rdata);
    push("ti_clear", 32'h0);
    mtc0(5'd11, 32'd20);
    chk({31'd0, cause[30]});

    // delay-slot AdEL exception
    exc_valid = 1'b1; exc_code = 5'd4;
    exc_pc = 32'h100; ds = 1'b1; badv = 32'h203;
    push("ds_epc", 32'h0000_00FC);
    push("ds_cause", 32'h8000_0010);
    push("ds_bva", 32'h0000_0203);
    push("ds_status", 32'h1000_0002);
    cyc();
    exc_valid = 1'b0; ds = 1'b0;
    chk(epc); chk(cause); chk(bva); chk(status);

    // nested syscall
    exc_valid = 1'b1; exc_code = 5'd8;
    exc_pc = 32'h400; badv = 32'h999;
    push("nest_epc", 32'h0000_00FC);
    push("nest_cause", 32'h8000_0020);
    push("nest_bva", 32'h0000_0203);
    cyc();
    exc_valid = 1'b0;
    chk(epc); chk(cause); chk(bva);

    // eret clears EXL
    eret = 1'b1;
    push("eret_status", 32'h1000_0000);
    cyc();
    eret = 1'b0;
    chk(status);

    // interrupt request path
    mtc0(5'd12, 32'h0000_0401);
    int_l = 6'b000001;
    push("irq_pre", 32'h0);
    push("irq_ip", 32'h04);
    #1;
    chk({31'd0, int_req});
    chk({24'd0, cause[15:8]});
    push("irq_one", 32'h1);
    cyc();
    chk({31'd0, int_req});
    push("irq_exl_lag", 32'h1);
    mtc0(5'd12, 32'h0000_0403);
    chk({31'd0, int_req});
    push("irq_exl_off", 32'h0);
    cyc();
    chk({31'd0, int_req});
    int_l = 6'b0;
    eret = 1'b1;
    push("eret2_status", 32'h0000_0401);
    cyc();
    eret = 1'b0;
    chk(status);

    // exc + eret + MTC0 Status=0 together
    exc_valid = 1'b1; eret = 1'b1; exc_code = 5'd0;
    exc_pc = 32'h500; ds = 1'b0;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0;
    push("combo_status", 32'h0000_0002);
    push("combo_epc", 32'h0000_0500);
    push("combo_cause", 32'h0);
    cyc();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    chk(status); chk(epc); chk(cause);

    // read bypass
    int_l = 6'b000100;
    we = 1'b1; waddr = 5'd13; raddr = 5'd13;
    wdata = 32'hFFFF_FFFF;
    push("byp_cause", 32'h00C0_1300);
    #1;
    chk(rdata);
    push("cause_wr", 32'h00C0_1300);
    cyc();
    we = 1'b0;
    chk(cause);
    we = 1'b1; waddr = 5'd12; raddr = 5'd12;
    push("byp_status", 32'h1000_FF03);
    #1;
    chk(rdata);
    waddr = 5'd8; raddr = 5'd8; wdata = 32'h0;
    push("byp_bva_ro", 32'h0000_0203);
    #1;
    chk(rdata);
    waddr = 5'd3; raddr = 5'd3; wdata = 32'hFFFF_FFFF;
    push("byp_unused", 32'h0);
    #1;
    chk(rdata);
    cyc();
    we = 1'b0; int_l = 6'b0;
    push("bva_kept", 32'h0000_0203);
    chk(bva);

    // EBase mask
    push("ebase_wr", 32'hBFFF_F000);
    mtc0(5'd15, 32'hFFFF_FFFF);
    chk(ebase);

    // Count wrap (DIV=1) and TIMER_EN=0 reads
    raddr = 5'd9;
    push("wrap_load", 32'hFFFF_FFFF);
    push("notimer_count", 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    #1;
    chk(u1_rdata);
    chk(u2_rdata);
    push("wrap_zero", 32'h0);
    cyc();
    chk(u1_rdata);

    // reset during exception
    exc_valid = 1'b1; exc_code = 5'd5;
    exc_pc = 32'h900; badv = 32'h777;
    rst = 1'b1;
    push("rx_status", 32'h1000_0000);
    push("rx_epc", 32'h0);
    push("rx_bva", 32'h0);
    push("rx_cause", 32'h0);
    push("rx_ebase", 32'h8000_0000);
    push("rx_count", 32'h0);
    cyc();
    rst = 1'b0; exc_valid = 1'b0;
    #1;
    chk(status); chk(epc); chk(bva);
    chk(cause); chk(ebase); chk(rdata);

    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0",
             sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter HW_INT_W, default 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[HW_INT_W+1:2].
REQ-002 SHALL have parameter COUNT_DIV, default 2, clock cycles per Count increment (1..16).
REQ-003 SHALL have parameter EBASE_RST, default 32'h8000_0000, EBase reset value.
REQ-004 SHALL have parameter TIMER_EN, default 1, Count/Compare timer present.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 we_i  in  1  MTC0 write strobe.
REQ-008 waddr_i  in  5  MTC0 register number.
REQ-009 wdata_i  in  32  MTC0 data.
REQ-010 raddr_i  in  5  MFC0 register number.
REQ-011 int_i  in  HW_INT_W  level-sensitive hardware interrupts.
REQ-012 exc_valid_i  in  1  exception commit this cycle.
REQ-013 exc_code_i  in  5  ExcCode of committing exception.
REQ-014 eret_i  in  1  ERET commit.
REQ-015 exc_pc_i  in  32  PC of excepting instruction.
REQ-016 in_delay_slot_i  in  1  excepting instruction is in a delay slot.
REQ-017 badvaddr_i  in  32  faulting address.
REQ-018 rdata_o  out  32  MFC0 read data, combinational.
REQ-019 status_o, cause_o, epc_o, ebase_o, badvaddr_o  out  32 each  live register values.
REQ-020 int_req_o  out  1  registered interrupt request to pipeline.

Function
REQ-021 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), EBase(15); other addresses read 0, ignore writes.
REQ-022 Write masks: Status bits {28,15:8,1,0} writable, others read as reset value; Cause only IP[1:0] (bits 9:8) and bits 23:22 writable; EBase bits 29:12 writable; BadVAddr read-only via MTC0.
REQ-023 Prescaler counts 0..COUNT_DIV-1; Count increments by 1 at wrap, 32'hFFFF_FFFF wraps to 0.
REQ-024 MTC0 Count loads wdata and clears prescaler; a load overrides that cycle's increment.
REQ-025 Cause.TI (bit 30) sets sticky when Count==Compare after update; MTC0 Compare clears TI, and clear wins over a same-cycle set.
REQ-026 Cause.IP[7] = TI OR int_i[5] (when HW_INT_W=6); Cause.IP[HW_INT_W+1:2] sampled from int_i every cycle; unused IP bits read 0.
REQ-027 int_req_o registered: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), one-cycle latency.
REQ-028 On exc_valid_i with EXL=0: EPC = in_delay_slot_i ? exc_pc_i-4 : exc_pc_i; Cause.BD = in_delay_slot_i.
REQ-029 On exc_valid_i with EXL=1: EPC and BD unchanged.
REQ-030 On every exc_valid_i: Cause.ExcCode = exc_code_i; EXL set.
REQ-031 BadVAddr loads badvaddr_i only for ExcCode 4 (AdEL) or 5 (AdES).
REQ-032 eret_i clears EXL; if exc_valid_i and eret_i are both asserted, the exception wins.
REQ-033 Exception/ERET updates take priority over a same-cycle MTC0 to the same field; the MTC0 is applied to non-conflicting fields.
REQ-034 Read bypass: if we_i and waddr_i==raddr_i, rdata_o returns the masked merge of wdata_i with the current value.
REQ-035 TIMER_EN=0: Count/Compare read 0, TI constant 0.

Reset
REQ-036 Synchronous rst: Status=32'h1000_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0, EBase=EBASE_RST, int_req_o=0.
REQ-037 Reset mid-exception discards the pending update; outputs match REQ-036 on the following cycle.

Structure
REQ-038 Register numbers, ExcCode values and the Status/Cause bit positions and write masks SHALL live in the shared package cp0_pkg.
REQ-039 Count/Compare/prescaler/TI logic SHALL be sub-module cp0_timer (COUNT_DIV, TIMER_EN parameters).

Verification
REQ-040 Timer: COUNT_DIV=2, Compare=5, Count=0 -> TI=1 and Cause[30]=1 after 10 cycles; MTC0 Compare=20 -> TI=0 the next cycle.
REQ-041 Delay-slot exception: EXL=0, exc_code=4, pc=32'h100, ds=1, badvaddr=32'h203 -> EPC=32'hFC, BD=1, ExcCode=4, BadVAddr=32'h203, EXL=1.
REQ-042 Nested exception: EXL=1, syscall with pc=32'h400 -> EPC unchanged, ExcCode=8.
REQ-043 Interrupt: Status=32'h0000_0401, int_i[0]=1 -> int_req_o=1 one cycle later; set EXL -> int_req_o=0.
REQ-044 Simultaneous exc_valid_i and eret_i plus MTC0 Status=0 -> EXL=1; read bypass on Cause returns masked merged value.
REQ-045 Count=32'hFFFF_FFFF, COUNT_DIV=1 -> Count=0 next cycle; rst asserted during exception -> Status=32'h1000_0000.
